// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, image byte-order constants,
// default memory geometry, and state-decode helpers for the registered FSM outputs.
// No logic of its own; imported by prog_loader and prog_loader_byte_assembler.
package prog_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_LEN_CHK,
        S_DATA,
        S_WRITE,
        S_CKSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int LOADER_IM_WORDS       = 256;
    localparam int LOADER_ADDR_W         = 10;
    localparam int LOADER_BYTES_PER_WORD = 4;   // each word arrives MSB first
    localparam int LOADER_LEN_BYTES      = 2;   // word count arrives high byte first

    // States in which the loader takes a byte off the stream.
    function automatic logic accepts_bytes(state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CKSUM);
    endfunction

    function automatic logic is_busy(state_t s);
        return !((s == S_IDLE) || (s == S_DONE) || (s == S_ERR));
    endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Purpose : packs 4 stream bytes MSB first into a 32-bit word.
// Latency : word register holds the full word the cycle after the 4th byte.
// Backpr. : none; accepts a byte whenever i_byte_vld is high.
// Ports   : clk, rst (sync, active-high), i_clr (restart word), i_byte_vld/i_byte (accepted byte),
//           o_word (shift register contents), o_word_vld (pulse while the 4th byte is accepted).
module prog_loader_byte_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_vld
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;

    assign o_word     = r_word;
    assign o_word_vld = i_byte_vld && (r_cnt == 2'(LOADER_BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= 32'd0;
            r_cnt  <= 2'd0;
        end else if (i_clr) begin
            r_cnt  <= 2'd0;
        end else if (i_byte_vld) begin
            r_word <= {r_word[23:0], i_byte};
            r_cnt  <= r_cnt + 2'd1;     // wraps naturally after the 4th byte
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Purpose : streams a length-prefixed program image into instruction memory, holding the CPU in reset.
// Latency : last data byte accepted at N -> im write at N+1 -> done / cpu_rst release at N+2.
// Backpr. : rx_ready low outside byte-accepting states and during the write cycle; rx_valid low stalls.
// Ports   : clk, rst (sync, active-high), start pulse; byte stream rx_data/rx_valid/rx_ready;
//           im write port IM_enable/IM_write/IM_read/IM_address/IM_in; cpu_rst, busy, done, error.
// Option  : define LOADER_CKSUM_EN to require a trailing XOR-of-data-bytes checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IM_WORDS = LOADER_IM_WORDS,
    parameter int ADDR_W   = LOADER_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              IM_enable,
    output logic              IM_write,
    output logic              IM_read,
    output logic [ADDR_W-1:0] IM_address,
    output logic [31:0]       IM_in,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = ADDR_W - 2;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rx_ready;
    logic             r_im_wr;
    logic             r_cpu_rst;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [15:0]      r_remain;     // words still to write; holds the full count after LEN_LO
    logic [IDX_W-1:0] r_idx;        // word index of the next write
`ifdef LOADER_CKSUM_EN
    logic [7:0]       r_xor;
`endif

    logic        w_xfer;
    logic        w_start_ok;
    logic        w_data_xfer;
    logic [31:0] w_word;
    logic        w_word_vld;

    assign w_xfer      = rx_valid && r_rx_ready;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_data_xfer = w_xfer && (r_state == S_DATA);

    prog_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start_ok),
        .i_byte_vld (w_data_xfer),
        .i_byte     (rx_data),
        .o_word     (w_word),
        .o_word_vld (w_word_vld)
    );

    // End-of-image target: the checksum byte when enabled, otherwise straight to DONE.
    state_t w_tail;
`ifdef LOADER_CKSUM_EN
    assign w_tail = S_CKSUM;
`else
    assign w_tail = S_DONE;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (w_start_ok) w_state_nxt = S_LEN_HI;
            S_LEN_HI:              if (w_xfer) w_state_nxt = S_LEN_LO;
            S_LEN_LO:              if (w_xfer) w_state_nxt = S_LEN_CHK;
            // One cycle to judge the count, so the range compare never sits behind the byte input.
            S_LEN_CHK: begin
                if (r_remain == 16'd0)             w_state_nxt = w_tail;
                else if (r_remain > 16'(IM_WORDS)) w_state_nxt = S_ERR;
                else                               w_state_nxt = S_DATA;
            end
            S_DATA:                if (w_word_vld) w_state_nxt = S_WRITE;
            S_WRITE:               w_state_nxt = (r_remain == 16'd1) ? w_tail : S_DATA;
`ifdef LOADER_CKSUM_EN
            S_CKSUM:               if (w_xfer) w_state_nxt = (rx_data == r_xor) ? S_DONE : S_ERR;
`endif
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered by decoding the next state, so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_im_wr    <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_remain   <= 16'd0;
            r_idx      <= '0;
`ifdef LOADER_CKSUM_EN
            r_xor      <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rx_ready <= accepts_bytes(w_state_nxt);
            r_im_wr    <= (w_state_nxt == S_WRITE);
            r_cpu_rst  <= (w_state_nxt != S_DONE);
            r_busy     <= is_busy(w_state_nxt);
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= (w_state_nxt == S_ERR);

            case (r_state)
                S_IDLE, S_DONE, S_ERR: if (w_start_ok) begin
                    r_idx <= '0;
`ifdef LOADER_CKSUM_EN
                    r_xor <= 8'd0;
`endif
                end
                S_LEN_HI: if (w_xfer) r_remain[15:8] <= rx_data;
                S_LEN_LO: if (w_xfer) r_remain[7:0]  <= rx_data;
`ifdef LOADER_CKSUM_EN
                S_DATA:   if (w_xfer) r_xor <= r_xor ^ rx_data;
`endif
                S_WRITE: begin
                    r_remain <= r_remain - 16'd1;
                    // Hold the index on the last word so the address never wraps past the top.
                    if (r_remain != 16'd1) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rx_ready   = r_rx_ready;
    assign IM_enable  = r_im_wr;
    assign IM_write   = r_im_wr;
    assign IM_read    = 1'b0;
    assign IM_address = {r_idx, 2'b00};
    assign IM_in      = w_word;
    assign cpu_rst    = r_cpu_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Purpose : directed bench for prog_loader; expected im writes go into a queue checked by a monitor.
// Latency : checks write timing and done/error timing relative to the last accepted byte.
// Backpr. : drives rx_valid with optional random idle gaps and honours rx_ready.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        IM_enable;
    logic        IM_write;
    logic        IM_read;
    logic [9:0]  IM_address;
    logic [31:0] IM_in;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .IM_enable  (IM_enable),
        .IM_write   (IM_write),
        .IM_read    (IM_read),
        .IM_address (IM_address),
        .IM_in      (IM_in),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          wr_count = 0;
    logic [7:0]  exp_xor = 8'd0;
    logic [41:0] exp_q[$];          // {address, data} of each expected im write

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        logic [41:0] e;
        forever begin
            @(negedge clk);
            if (!rst && IM_write) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", IM_address, IM_in);
                end else begin
                    e = exp_q.pop_front();
                    chk("im_write", {21'd0, IM_enable, IM_read, IM_address, IM_in}, {21'd0, 1'b1, 1'b0, e});
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Returns at posedge+1 just after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        @(posedge clk); #1;
        if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk); #1;
                rx_valid = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
        total++;
        bad++;
        $display("FAIL byte_timeout: got rx_ready=0 for 50 cycles expected 1 (byte %h)", b);
    endtask

    task automatic send_len(input logic [15:0] n, input bit rnd);
        exp_xor = 8'd0;
        send_byte(n[15:8], rnd);
        send_byte(n[7:0], rnd);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input bit rnd);
        logic [9:0] a;
        a = 10'(idx * 4);
        exp_q.push_back({a, w});
        for (int k = 3; k >= 0; k--) begin
            exp_xor = exp_xor ^ w[k*8 +: 8];
            send_byte(w[k*8 +: 8], rnd);
        end
    endtask

    task automatic wait_status(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || error) return;
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got done=0 error=0 expected done or error", name);
    endtask

    task automatic finish_image(input string name);
`ifdef LOADER_CKSUM_EN
        send_byte(exp_xor, 1'b0);
`endif
        wait_status(name);
        chk({name, "_status"}, {60'd0, done, cpu_rst, busy, error}, {60'd0, 4'b1000});
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vals", {14'd0, rx_ready, IM_enable, IM_write, IM_read, IM_address, IM_in, cpu_rst, busy, done, error},
                          {14'd0, 4'b0000, 10'd0, 32'd0, 4'b1000});
        @(posedge clk); #1 rst = 1'b0;

        // Two-word image, with write -> done latency checked.
        pulse_start();
        @(negedge clk);
        chk("start_busy", {61'd0, busy, cpu_rst, done}, {61'd0, 3'b110});
        send_len(16'd2, 1'b0);
        send_word(32'h12345678, 0, 1'b0);
        send_word(32'hDEADBEEF, 1, 1'b0);
`ifdef LOADER_CKSUM_EN
        send_byte(exp_xor, 1'b0);
        @(negedge clk);
        chk("t1_done", {60'd0, done, cpu_rst, busy, error}, {60'd0, 4'b1000});
`else
        @(negedge clk);
        chk("t1_not_done_during_write", {63'd0, done}, 64'd0);
        @(negedge clk);
        chk("t1_done", {60'd0, done, cpu_rst, busy, error}, {60'd0, 4'b1000});
`endif
        chk("t1_drained", 64'(exp_q.size()), 64'd0);

        // Zero-length image: done two cycles after the second length byte, no writes.
        wr_count = 0;
        pulse_start();
        send_len(16'd0, 1'b0);
`ifdef LOADER_CKSUM_EN
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        chk("t2_done", {60'd0, done, cpu_rst, busy, error}, {60'd0, 4'b1000});
`else
        @(negedge clk);
        chk("t2_not_done_yet", {63'd0, done}, 64'd0);
        @(negedge clk);
        chk("t2_done", {60'd0, done, cpu_rst, busy, error}, {60'd0, 4'b1000});
`endif
        chk("t2_no_writes", 64'(wr_count), 64'd0);

        // Oversized count 257 -> error, then recovery with a fresh start.
        wr_count = 0;
        pulse_start();
        send_len(16'h0101, 1'b0);
        wait_status("t3_err");
        chk("t3_error", {60'd0, done, cpu_rst, busy, error}, {60'd0, 4'b0101});
        chk("t3_no_writes", 64'(wr_count), 64'd0);
        pulse_start();
        @(negedge clk);
        chk("t3_restart_clears", {62'd0, error, busy}, {62'd0, 2'b01});
        send_len(16'd1, 1'b0);
        send_word(32'hCAFEBABE, 0, 1'b0);
        finish_image("t3_recover");

        // Three words with random valid gaps; a start while busy must be ignored.
        wr_count = 0;
        pulse_start();
        send_len(16'd3, 1'b1);
        send_word(32'hA5A50001, 0, 1'b1);
        pulse_start();
        @(negedge clk);
        chk("t4_start_ignored", {61'd0, busy, done, error}, {61'd0, 3'b100});
        send_word(32'h0BADF00D, 1, 1'b1);
        send_word(32'h80000003, 2, 1'b1);
        finish_image("t4");
        chk("t4_write_count", 64'(wr_count), 64'd3);

        // Reset after five data bytes: outputs return to reset values, then reload.
        pulse_start();
        send_len(16'd3, 1'b0);
        send_word(32'h11223344, 0, 1'b0);
        send_byte(8'h55, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_reset_vals", {14'd0, rx_ready, IM_enable, IM_write, IM_read, IM_address, IM_in, cpu_rst, busy, done, error},
                             {14'd0, 4'b0000, 10'd0, 32'd0, 4'b1000});
        chk("t5_drained_before_rst", 64'(exp_q.size()), 64'd0);
        pulse_start();
        send_len(16'd2, 1'b0);
        send_word(32'h12345678, 0, 1'b0);
        send_word(32'hDEADBEEF, 1, 1'b0);
        finish_image("t5_reload");

`ifdef LOADER_CKSUM_EN
        // Checksum of 01 02 03 04 is 04; 05 must abort.
        pulse_start();
        send_len(16'd1, 1'b0);
        send_word(32'h01020304, 0, 1'b0);
        send_byte(8'h04, 1'b0);
        @(negedge clk);
        chk("t6_cksum_ok", {60'd0, done, cpu_rst, busy, error}, {60'd0, 4'b1000});
        pulse_start();
        send_len(16'd1, 1'b0);
        send_word(32'h01020304, 0, 1'b0);
        send_byte(8'h05, 1'b0);
        @(negedge clk);
        chk("t6_cksum_bad", {60'd0, done, cpu_rst, busy, error}, {60'd0, 4'b0101});
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
